// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared types, helpers and timing defaults for the button conditioner
// Contents:
//   btn_state_t : per-button hold/repeat state encoding
//   clog2       : ceiling log2 for sizing counters from parameters
//   DEFAULT_*   : timing constants for the 50 MHz Mojo clock
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD_WAIT = 2'd1,
    HELD_RPT  = 2'd2
  } btn_state_t;

  localparam int DEFAULT_N_BTN           = 5;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;   // 20 ms
  localparam int DEFAULT_REPEAT_DELAY    = 25000000;  // 500 ms
  localparam int DEFAULT_REPEAT_PERIOD   = 5000000;   // 100 ms

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one button: 2-flop synchroniser, debouncer, edge pulses, auto-repeat
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   raw      : raw asynchronous button input
//   level    : debounced level
//   press    : one-cycle pulse on an accepted rising edge
//   rel      : one-cycle pulse on an accepted falling edge
//   rpt      : one-cycle auto-repeat pulse while held
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
  parameter int REPEAT_EN       = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int DBC_W  = clog2(DEBOUNCE_CYCLES);
  localparam int HC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HC_W   = (clog2(HC_MAX) < 1) ? 1 : clog2(HC_MAX);

  localparam logic [DBC_W-1:0] DBC_LAST    = DBC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HC_W-1:0]  DELAY_LAST  = HC_W'(REPEAT_DELAY - 1);
  localparam logic [HC_W-1:0]  PERIOD_LAST = HC_W'(REPEAT_PERIOD - 1);

  logic             s1, s2;
  logic [DBC_W-1:0] dbc;
  logic             differ, accept, rise_acc, fall_acc;

  btn_state_t       state, state_next;
  logic [HC_W-1:0]  hc, hc_next;
  logic             rpt_next;

  // s2 is the only copy of the button used past this point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  assign differ   = (s2 != level);
  assign accept   = differ && (dbc == DBC_LAST);
  assign rise_acc = accept && !level;
  assign fall_acc = accept && level;

  // Any sample agreeing with the current level restarts the count, which
  // is what rejects bounce and short glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbc   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= rise_acc;
      rel   <= fall_acc;
      if (!differ || accept) dbc <= '0;
      else                   dbc <= dbc + 1'b1;
      if (accept) level <= s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hc    <= '0;
      rpt   <= 1'b0;
    end else begin
      state <= state_next;
      hc    <= hc_next;
      rpt   <= rpt_next;
    end
  end

  // A release accepted on the same edge as a repeat match wins; the
  // repeat is dropped. Press happens on entry to HELD_WAIT, so a repeat
  // can never coincide with it.
  always_comb begin
    state_next = state;
    hc_next    = hc;
    rpt_next   = 1'b0;
    case (state)
      IDLE: begin
        if (rise_acc) begin
          state_next = HELD_WAIT;
          hc_next    = '0;
        end
      end
      HELD_WAIT: begin
        if (fall_acc) begin
          state_next = IDLE;
          hc_next    = '0;
        end else if (hc == DELAY_LAST) begin
          // With repeat disabled hc simply parks here instead of wrapping.
          if (REPEAT_EN != 0) begin
            rpt_next   = 1'b1;
            hc_next    = '0;
            state_next = HELD_RPT;
          end
        end else begin
          hc_next = hc + 1'b1;
        end
      end
      HELD_RPT: begin
        if (fall_acc) begin
          state_next = IDLE;
          hc_next    = '0;
        end else if (hc == PERIOD_LAST) begin
          rpt_next = 1'b1;
          hc_next  = '0;
        end else begin
          hc_next = hc + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        hc_next    = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - conditions N_BTN raw push-buttons into levels and move events
// Ports:
//   clk, rst    : 50 MHz clock and asynchronous active-high reset
//   btn_raw     : raw asynchronous buttons (0 up, 1 center, 2 down, 3 left, 4 right)
//   btn_level   : debounced levels
//   btn_press   : one-cycle pulse per accepted press
//   btn_release : one-cycle pulse per accepted release
//   btn_repeat  : one-cycle auto-repeat pulses while held
//   btn_event   : press or repeat, drives the tilesort direction inputs
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BTN           = DEFAULT_N_BTN,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
  parameter int REPEAT_EN       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic [N_BTN-1:0] btn_event
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_EN)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .level (btn_level[i]),
      .press (btn_press[i]),
      .rel   (btn_release[i]),
      .rpt   (btn_repeat[i])
    );
  end

  // Both terms are registered and mutually exclusive per bit.
  assign btn_event = btn_press | btn_repeat;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner
module tb_button_conditioner;

  localparam int N  = 5;
  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat, btn_event;

  int n_total = 0;
  int n_pass  = 0;

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .btn_event(btn_event)
  );

  always #5 clk = ~clk;

  // Reference model: a level flips once the last DC synchronised samples
  // all disagree with it; repeats fall at fixed offsets from the press.
  logic [N-1:0]    p1 = '0, p2 = '0, m_lvl = '0;
  logic [DC-1:0]   hist [N];
  int              pcyc [N];
  int              cyc = 0;
  logic [N-1:0]    e_lvl = '0, e_prs = '0, e_rel = '0, e_rpt = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p1 = '0; p2 = '0; m_lvl = '0;
      e_lvl = '0; e_prs = '0; e_rel = '0; e_rpt = '0;
      for (int b = 0; b < N; b++) begin hist[b] = '0; pcyc[b] = 0; end
      cyc = 0;
    end else begin
      cyc++;
      for (int b = 0; b < N; b++) begin
        logic s, flip;
        int d;
        s = p2[b]; p2[b] = p1[b]; p1[b] = btn_raw[b];
        hist[b] = {hist[b][DC-2:0], s};
        flip = (hist[b] == {DC{~m_lvl[b]}});
        e_prs[b] = flip && !m_lvl[b];
        e_rel[b] = flip && m_lvl[b];
        e_rpt[b] = 1'b0;
        if (m_lvl[b] && !flip) begin
          d = cyc - pcyc[b];
          if (d == RD || (d > RD && (d - RD) % RP == 0)) e_rpt[b] = 1'b1;
        end
        if (flip) begin
          m_lvl[b] = ~m_lvl[b];
          if (m_lvl[b]) pcyc[b] = cyc;
        end
        e_lvl[b] = m_lvl[b];
      end
    end
  end

  wire [5*N-1:0] dut_v = {btn_level, btn_press, btn_release, btn_repeat, btn_event};
  wire [5*N-1:0] mdl_v = {e_lvl, e_prs, e_rel, e_rpt, e_prs | e_rpt};

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++;
      if (dut_v !== '0) $display("FAIL reset_outputs k=%0d got=%h exp=0", k, dut_v);
      else n_pass++;
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_total++;
      if (dut_v !== mdl_v) $display("FAIL reset_idle_model k=%0d got=%h exp=%h", k, dut_v, mdl_v);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk); #1 btn_raw[0] = (k < 9);
      @(negedge clk);
      n_total++;
      if (dut_v !== mdl_v) $display("FAIL clean_model k=%0d got=%h exp=%h", k, dut_v, mdl_v);
      else n_pass++;
      n_total++;
      if ({btn_level[0], btn_press[0], btn_event[0]} !== {(k >= 6 && k < 15), k == 6, k == 6})
        $display("FAIL clean_press k=%0d got lvl/prs/evt=%b%b%b", k, btn_level[0], btn_press[0], btn_event[0]);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    int presses = 0;
    for (int k = 0; k <= 26; k++) begin
      @(posedge clk); #1
      btn_raw[1] = (k == 0 || k == 2 || (k >= 4 && k < 14));
      @(negedge clk);
      n_total++;
      if (dut_v !== mdl_v) $display("FAIL bounce_model k=%0d got=%h exp=%h", k, dut_v, mdl_v);
      else n_pass++;
      if (btn_press[1]) presses++;
      n_total++;
      if (btn_press[1] !== (k == 10)) $display("FAIL bounce_press k=%0d got=%b exp=%b", k, btn_press[1], k == 10);
      else n_pass++;
    end
    n_total++;
    if (presses !== 1) $display("FAIL bounce_count got=%0d exp=1", presses);
    else n_pass++;
  endtask

  task automatic test_glitch();
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk); #1 btn_raw[2] = (k < 3);
      @(negedge clk);
      n_total++;
      if ({btn_level[2], btn_press[2], btn_event[2]} !== 3'b000 || dut_v !== mdl_v)
        $display("FAIL glitch k=%0d got=%h exp=%h", k, dut_v, mdl_v);
      else n_pass++;
    end
  endtask

  task automatic test_auto_repeat();
    int rpts [$];
    for (int k = 0; k <= 40; k++) begin
      @(posedge clk); #1 btn_raw[3] = (k < 25);
      @(negedge clk);
      n_total++;
      if (dut_v !== mdl_v) $display("FAIL repeat_model k=%0d got=%h exp=%h", k, dut_v, mdl_v);
      else n_pass++;
      if (btn_repeat[3]) rpts.push_back(k);
      if (k == 6) begin
        n_total++;
        if (btn_press[3] !== 1'b1) $display("FAIL repeat_press got=%b exp=1", btn_press[3]);
        else n_pass++;
      end
      if (k == 31) begin
        n_total++;
        if (btn_release[3] !== 1'b1) $display("FAIL repeat_release got=%b exp=1", btn_release[3]);
        else n_pass++;
      end
      if (k >= 31) begin
        n_total++;
        if (btn_repeat[3] !== 1'b0) $display("FAIL repeat_after_release k=%0d got=%b exp=0", k, btn_repeat[3]);
        else n_pass++;
      end
    end
    n_total++;
    if (rpts.size() < 3 || rpts[0] != 16 || rpts[1] != 19 || rpts[2] != 22)
      $display("FAIL repeat_times got n=%0d first=%0d exp 16,19,22", rpts.size(), rpts.size() > 0 ? rpts[0] : -1);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk); #1 btn_raw[4] = (k < 8); btn_raw[0] = (k < 8);
      @(negedge clk);
      n_total++;
      if (dut_v !== mdl_v) $display("FAIL simul_model k=%0d got=%h exp=%h", k, dut_v, mdl_v);
      else n_pass++;
      n_total++;
      if ({btn_press[4], btn_press[0]} !== {2{k == 6}})
        $display("FAIL simul_press k=%0d got=%b%b exp=%b", k, btn_press[4], btn_press[0], k == 6);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k <= 36; k++) begin
      @(posedge clk); #1 btn_raw[0] = 1'b1;
      if (k == 5 || k == 27) rst = 1'b0;
      if (k == 3 || k == 25) begin
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (dut_v !== '0) $display("FAIL reset_async k=%0d got=%h exp=0", k, dut_v);
        else n_pass++;
      end
      @(negedge clk);
      n_total++;
      if (dut_v !== mdl_v) $display("FAIL reset_mid_model k=%0d got=%h exp=%h", k, dut_v, mdl_v);
      else n_pass++;
      n_total++;
      if ({btn_press[0], btn_repeat[0]} !== {(k == 11 || k == 33), (k == 21 || k == 24)})
        $display("FAIL reset_mid_pulses k=%0d got prs/rpt=%b%b", k, btn_press[0], btn_repeat[0]);
      else n_pass++;
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1 btn_raw = '0;
      @(negedge clk);
      n_total++;
      if (dut_v !== mdl_v) $display("FAIL reset_mid_tail k=%0d got=%h exp=%h", k, dut_v, mdl_v);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int remain [N];
    for (int b = 0; b < N; b++) remain[b] = 1;
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #1;
      for (int b = 0; b < N; b++) begin
        remain[b]--;
        if (remain[b] <= 0) begin
          btn_raw[b] = ~btn_raw[b];
          remain[b] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(5, 30);
        end
      end
      @(negedge clk);
      n_total++;
      if (dut_v !== mdl_v) $display("FAIL random_model k=%0d got=%h exp=%h", k, dut_v, mdl_v);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_auto_repeat();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
